// File: rtl/dtfag_rom_scheduler_pkg.sv
// Shared constants and FSM encoding for the DTFAG twiddle ROM scheduler.
// ROMA_width / D_width keep their historical define names for the ROM wrapper.
`ifndef ROMA_width
`define ROMA_width 4
`endif
`ifndef D_width
`define D_width 16
`endif

package dtfag_rom_scheduler_pkg;
  localparam int ROMA_W  = `ROMA_width;
  localparam int D_W     = `D_width;
  localparam int STAGE_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/dtfag_tw_addr_gen.sv
// Radix-4 twiddle exponent generator: k, 2k, 3k (mod 2^ROMA_W) and the
// last k of a stage, which shrinks by a factor of four per stage.
module dtfag_tw_addr_gen #(
  parameter int ROMA_W    = 4,
  parameter int STAGE_W   = 2,
  parameter int LAST_ADDR = (1 << ROMA_W) - 1
) (
  input  logic [ROMA_W-1:0]  k,
  input  logic [STAGE_W-1:0] stage,
  output logic [ROMA_W-1:0]  ma0,
  output logic [ROMA_W-1:0]  ma1,
  output logic [ROMA_W-1:0]  ma2,
  output logic [ROMA_W-1:0]  lim
);
  localparam logic [ROMA_W-1:0] LAST_A = ROMA_W'(LAST_ADDR);

  logic [STAGE_W:0] shamt_s;

  // Address triple and per-stage limit; products wrap at the ROM size.
  always_comb begin
    shamt_s = {stage, 1'b0};
    ma0     = k;
    ma1     = {k[ROMA_W-2:0], 1'b0};
    ma2     = k + {k[ROMA_W-2:0], 1'b0};
    lim     = LAST_A >> shamt_s;
  end
endmodule

// File: rtl/dtfag_rom_scheduler.sv
// Walks FFT stages, issuing twiddle ROM reads and tagging the returned sets
// with valid/stage/last under consumer backpressure.
module dtfag_rom_scheduler #(
  parameter int ROMA_W    = dtfag_rom_scheduler_pkg::ROMA_W,
  parameter int STAGE_W   = dtfag_rom_scheduler_pkg::STAGE_W,
  parameter int LAST_ADDR = (1 << ROMA_W) - 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [STAGE_W-1:0] cfg_first_stage,
  input  logic [STAGE_W-1:0] cfg_last_stage,
  input  logic               tw_ready,
  output logic               ROM_CEN,
  output logic [STAGE_W-1:0] FFT_stage,
  output logic [ROMA_W-1:0]  MA0,
  output logic [ROMA_W-1:0]  MA1,
  output logic [ROMA_W-1:0]  MA2,
  output logic               tw_valid,
  output logic [STAGE_W-1:0] tw_stage,
  output logic               tw_last,
  output logic               busy,
  output logic               done
);
  import dtfag_rom_scheduler_pkg::state_e;
  import dtfag_rom_scheduler_pkg::ST_IDLE;
  import dtfag_rom_scheduler_pkg::ST_RUN;
  import dtfag_rom_scheduler_pkg::ST_DRAIN;
  import dtfag_rom_scheduler_pkg::ST_DONE;

  state_e             state_r, state_nxt_s;
  logic [ROMA_W-1:0]  k_r, lim_s;
  logic [STAGE_W-1:0] stage_r, last_stage_r, tw_stage_r;
  logic               tw_valid_r, tw_last_r;
  logic               issue_s, accept_s, at_lim_s, last_issue_s;

  dtfag_tw_addr_gen #(
    .ROMA_W   (ROMA_W),
    .STAGE_W  (STAGE_W),
    .LAST_ADDR(LAST_ADDR)
  ) u_addr_gen (
    .k    (k_r),
    .stage(stage_r),
    .ma0  (MA0),
    .ma1  (MA1),
    .ma2  (MA2),
    .lim  (lim_s)
  );

  // Next state and issue decision; abort overrides both start and issue.
  always_comb begin
    state_nxt_s  = state_r;
    issue_s      = 1'b0;
    accept_s     = 1'b0;
    at_lim_s     = (k_r == lim_s);
    last_issue_s = at_lim_s && (stage_r == last_stage_r);
    if (abort) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            accept_s    = 1'b1;
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          issue_s = tw_ready || !tw_valid_r;
          if (issue_s && last_issue_s) begin
            state_nxt_s = ST_DRAIN;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (tw_valid_r && tw_ready && tw_last_r) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_DRAIN;
          end
        end
        ST_DONE: state_nxt_s = ST_IDLE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State, counters and the one-cycle-delayed tags of the ROM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      k_r          <= '0;
      stage_r      <= '0;
      last_stage_r <= '0;
      tw_valid_r   <= 1'b0;
      tw_stage_r   <= '0;
      tw_last_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (abort) begin
        k_r        <= '0;
        stage_r    <= '0;
        tw_valid_r <= 1'b0;
        tw_stage_r <= '0;
        tw_last_r  <= 1'b0;
      end else if (accept_s) begin
        k_r          <= '0;
        stage_r      <= cfg_first_stage;
        last_stage_r <= (cfg_last_stage < cfg_first_stage) ? cfg_first_stage : cfg_last_stage;
      end else if (issue_s) begin
        tw_valid_r <= 1'b1;
        tw_stage_r <= stage_r;
        tw_last_r  <= last_issue_s;
        if (!at_lim_s) begin
          k_r <= k_r + ROMA_W'(1);
        end else if (!last_issue_s) begin
          k_r     <= '0;
          stage_r <= stage_r + STAGE_W'(1);
        end else begin
          k_r <= k_r;
        end
      end else begin
        if (tw_ready) begin
          tw_valid_r <= 1'b0;
        end else begin
          tw_valid_r <= tw_valid_r;
        end
        // Park the address counters once the run has fully completed.
        if (state_r == ST_DONE) begin
          k_r     <= '0;
          stage_r <= '0;
        end else begin
          k_r <= k_r;
        end
      end
    end
  end

  assign ROM_CEN   = !issue_s;
  assign FFT_stage = stage_r;
  assign tw_valid  = tw_valid_r;
  assign tw_stage  = tw_stage_r;
  assign tw_last   = tw_last_r;
  assign busy      = (state_r != ST_IDLE);
  assign done      = (state_r == ST_DONE);
endmodule

// File: tb/tb_dtfag_rom_scheduler.sv
// Directed bench for dtfag_rom_scheduler with a scoreboard of expected
// twiddle sets (ROMA_W=4, LAST_ADDR=15).
module tb_dtfag_rom_scheduler;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] cfg_first_stage = 2'd0;
  logic [1:0] cfg_last_stage = 2'd0;
  logic       tw_ready = 1'b1;
  logic       ROM_CEN, tw_valid, tw_last, busy, done;
  logic [1:0] FFT_stage, tw_stage;
  logic [3:0] MA0, MA1, MA2;

  dtfag_rom_scheduler #(.ROMA_W(4), .STAGE_W(2), .LAST_ADDR(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_first_stage(cfg_first_stage), .cfg_last_stage(cfg_last_stage),
    .tw_ready(tw_ready), .ROM_CEN(ROM_CEN), .FFT_stage(FFT_stage),
    .MA0(MA0), .MA1(MA1), .MA2(MA2), .tw_valid(tw_valid), .tw_stage(tw_stage),
    .tw_last(tw_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] stage;
    logic [3:0] k;
    logic       last;
  } item_t;

  item_t exp_q[$];
  item_t pend_q[$];
  int n_chk = 0, n_fail = 0, cyc = 0;
  int n_issue, n_done, n_busy, first_iss, last_iss, first_val, done_cyc, start_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic clr_stats();
    n_issue = 0; n_done = 0; n_busy = 0;
    first_iss = -1; last_iss = -1; first_val = -1; done_cyc = -1;
  endtask

  // Expected sequence of sets for one run, derived from the stage walk rules.
  task automatic gen_run(input logic [1:0] f, input logic [1:0] l);
    int le, lim;
    item_t it;
    le = (l < f) ? int'(f) : int'(l);
    for (int s = int'(f); s <= le; s++) begin
      lim = 15 >> (2 * s);
      for (int k = 0; k <= lim; k++) begin
        it.stage = 2'(s);
        it.k     = 4'(k);
        it.last  = (s == le) && (k == lim);
        exp_q.push_back(it);
      end
    end
  endtask

  task automatic mon();
    item_t it;
    logic [3:0] e1, e2;
    if (busy === 1'b1) n_busy++;
    if (tw_valid === 1'b1 && first_val < 0) first_val = cyc;
    if (ROM_CEN === 1'b0) begin
      n_issue++;
      if (first_iss < 0) first_iss = cyc;
      last_iss = cyc;
      if (exp_q.size() == 0) begin
        chk("issue_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        it = exp_q.pop_front();
        e1 = it.k << 1;
        e2 = it.k * 4'd3;
        chk("ma0", 32'(MA0), 32'(it.k));
        chk("ma1", 32'(MA1), 32'(e1));
        chk("ma2", 32'(MA2), 32'(e2));
        chk("fft_stage", 32'(FFT_stage), 32'(it.stage));
        pend_q.push_back(it);
      end
    end
    if (tw_valid === 1'b1 && tw_ready === 1'b1) begin
      if (pend_q.size() == 0) begin
        chk("valid_unexpected", 32'(pend_q.size()), 32'd1);
      end else begin
        it = pend_q.pop_front();
        chk("tw_stage", 32'(tw_stage), 32'(it.stage));
        chk("tw_last", 32'(tw_last), 32'(it.last));
      end
    end
    if (done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
      chk("busy_at_done", 32'(busy), 32'd1);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && n_done == 0; i++) tick();
    chk("done_seen", 32'(n_done), 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rom_cen"}, 32'(ROM_CEN), 32'd1);
    chk({tag, "_ma0"}, 32'(MA0), 32'd0);
    chk({tag, "_ma1"}, 32'(MA1), 32'd0);
    chk({tag, "_ma2"}, 32'(MA2), 32'd0);
    chk({tag, "_fft_stage"}, 32'(FFT_stage), 32'd0);
    chk({tag, "_tw_valid"}, 32'(tw_valid), 32'd0);
    chk({tag, "_tw_stage"}, 32'(tw_stage), 32'd0);
    chk({tag, "_tw_last"}, 32'(tw_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic run_full(input string tag);
    clr_stats();
    cfg_first_stage = 2'd0; cfg_last_stage = 2'd3; tw_ready = 1'b1;
    gen_run(2'd0, 2'd3);
    start = 1'b1; start_cyc = cyc;
    tick();
    start = 1'b0;
    wait_done(60);
    chk({tag, "_n_issue"}, 32'(n_issue), 32'd22);
    chk({tag, "_no_bubbles"}, 32'(last_iss - first_iss), 32'd21);
    chk({tag, "_first_issue"}, 32'(first_iss), 32'(start_cyc + 1));
    chk({tag, "_first_valid"}, 32'(first_val), 32'(start_cyc + 2));
    chk({tag, "_done_lat"}, 32'(done_cyc - last_iss), 32'd2);
    chk({tag, "_busy_span"}, 32'(n_busy), 32'(done_cyc - start_cyc));
    chk({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_pend_left"}, 32'(pend_q.size()), 32'd0);
    chk({tag, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int found;
    #3;
    chk_reset("reset");
    @(posedge clk); #1; rst_n = 1'b1;
    tick();
    chk_reset("idle");

    // Full four-stage run with the consumer always ready
    run_full("full");

    // Backpressure inside a single stage-1 run
    clr_stats();
    cfg_first_stage = 2'd1; cfg_last_stage = 2'd1;
    gen_run(2'd1, 2'd1);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    tw_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_rom_cen", 32'(ROM_CEN), 32'd1);
      chk("stall_ma0", 32'(MA0), 32'd1);
      chk("stall_valid", 32'(tw_valid), 32'd1);
      chk("stall_stage", 32'(tw_stage), 32'd1);
      tick();
    end
    tw_ready = 1'b1;
    wait_done(30);
    chk("bp_n_issue", 32'(n_issue), 32'd4);
    chk("bp_exp_left", 32'(exp_q.size()), 32'd0);
    chk("bp_pend_left", 32'(pend_q.size()), 32'd0);

    // Reversed configuration runs only the first stage
    clr_stats();
    cfg_first_stage = 2'd2; cfg_last_stage = 2'd0;
    gen_run(2'd2, 2'd0);
    start = 1'b1; tick(); start = 1'b0;
    wait_done(20);
    chk("rev_n_issue", 32'(n_issue), 32'd1);

    // Abort in stage 0 at k=7, then a single-set stage-3 run
    clr_stats();
    cfg_first_stage = 2'd0; cfg_last_stage = 2'd3;
    gen_run(2'd0, 2'd3);
    start = 1'b1; tick(); start = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (MA0 === 4'd7) found = 1;
      else tick();
    end
    chk("abort_reached_k7", 32'(found), 32'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rom_cen", 32'(ROM_CEN), 32'd1);
    chk("abort_valid", 32'(tw_valid), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (3) tick();
    chk("abort_no_done", 32'(n_done), 32'd0);
    exp_q.delete(); pend_q.delete();
    clr_stats();
    cfg_first_stage = 2'd3; cfg_last_stage = 2'd3;
    gen_run(2'd3, 2'd3);
    start = 1'b1; tick(); start = 1'b0;
    wait_done(20);
    chk("post_abort_n_issue", 32'(n_issue), 32'd1);

    // Start while busy is ignored; start+abort in IDLE is ignored
    clr_stats();
    cfg_first_stage = 2'd1; cfg_last_stage = 2'd1;
    gen_run(2'd1, 2'd1);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    start = 1'b1; cfg_first_stage = 2'd0; cfg_last_stage = 2'd3;
    tick();
    start = 1'b0;
    wait_done(30);
    chk("busy_start_n_issue", 32'(n_issue), 32'd4);
    chk("busy_start_exp_left", 32'(exp_q.size()), 32'd0);
    clr_stats();
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 32'd0);
    chk("start_abort_rom_cen", 32'(ROM_CEN), 32'd1);
    repeat (2) tick();
    chk("start_abort_n_issue", 32'(n_issue), 32'd0);
    chk("start_abort_n_busy", 32'(n_busy), 32'd0);

    // Asynchronous reset in stage 1, then an identical full run
    clr_stats();
    cfg_first_stage = 2'd0; cfg_last_stage = 2'd3;
    gen_run(2'd0, 2'd3);
    start = 1'b1; tick(); start = 1'b0;
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      if (FFT_stage === 2'd1) found = 1;
      else tick();
    end
    chk("reached_stage1", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset("midrun_reset");
    exp_q.delete(); pend_q.delete();
    @(posedge clk); #1; rst_n = 1'b1;
    tick();
    run_full("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dtfag_rom_scheduler.md
Name: dtfag_rom_scheduler

Overview:
Sequencer for the DTFAG twiddle ROM wrapper (three ROM ports, 16 banks each).
- On a start pulse it walks the configured FFT stages.
- Per stage it issues radix-4 twiddle exponent addresses k, 2k, 3k on MA0/MA1/MA2, drives ROM_CEN and the stage select, and tags each returned word set with valid/stage/last.
- Sits between the FFT control FSM and Memory_wrapper; the butterfly consumer applies backpressure through tw_ready.

Parameters:
ROMA_W, `ROMA_width, ROM address width (MA0..MA2).
STAGE_W, 2, stage index width (matches FFT_stage_in).
LAST_ADDR, 2**ROMA_W-1, final address of stage 0.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle start request; honoured only in IDLE
abort  in  1  synchronous abort to IDLE
cfg_first_stage  in  STAGE_W  first stage, sampled at accepted start
cfg_last_stage  in  STAGE_W  last stage, sampled at accepted start
tw_ready  in  1  consumer accepts current twiddle set
ROM_CEN  out  1  ROM chip enable, active-low
FFT_stage  out  STAGE_W  stage select to wrapper
MA0  out  ROMA_W  address k
MA1  out  ROMA_W  address 2k mod 2^ROMA_W
MA2  out  ROMA_W  address 3k mod 2^ROMA_W
tw_valid  out  1  ROM outputs hold a valid twiddle set
tw_stage  out  STAGE_W  stage of the set under tw_valid
tw_last  out  1  set under tw_valid is the final one of the run
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse when the run completes

Behaviour:
- Reset (async, rst_n=0): state IDLE. Output values: ROM_CEN=1, MA0/1/2=0, FFT_stage=0, tw_valid=0, tw_stage=0, tw_last=0, busy=0, done=0. Counters cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start & !abort. Latch first/last stage. If cfg_last_stage < cfg_first_stage, only cfg_first_stage runs. Set k=0, stage=first.
- Per-stage limit: lim = LAST_ADDR >> (2*stage); k runs 0..lim inclusive.
- issue = (state==RUN) & (tw_ready | !tw_valid).
  - ROM_CEN = !issue, combinational.
  - MA0 = k; MA1 = (k<<1) truncated to ROMA_W bits; MA2 = (k + (k<<1)) truncated to ROMA_W bits. All are combinational from the k register.
  - FFT_stage = stage register.
- ROM read latency is 1 cycle. tw_valid and tw_stage/tw_last update each cycle as follows:
  - issue: tw_valid<=1; tw_stage and tw_last take the tags of the issued address.
  - else if tw_ready: tw_valid<=0.
  - else: hold.
  - ROM data holds while ROM_CEN=1, so a stalled set stays stable.
- Counter advance on issue:
  - k<lim: k+1.
  - k==lim and stage<last: stage+1, k=0.
  - k==lim and stage==last: mark this issue last and go to DRAIN.
- DRAIN -> DONE when tw_valid & tw_ready & tw_last.
- DONE: done=1 for one cycle, busy still 1. DONE -> IDLE.
- Timing: start sampled at edge t; first issue in cycle t+1; tw_valid first high in cycle t+2.
- With tw_ready held high, one set is issued per cycle with no bubbles across stage boundaries.
- abort in any state: next cycle is IDLE with ROM_CEN=1, tw_valid=0 and no done pulse. abort has priority over start and over issue.
- start while busy: ignored.
- rst_n asserted mid-run: immediate return to the reset values.

Decomposition:
- Shared package/define file holds: ROMA_width and D_width (existing defines), state encoding localparams for IDLE/RUN/DRAIN/DONE, and STAGE_W.
- One sub-module is natural: dtfag_tw_addr_gen (k -> MA0/1/2, and lim from stage). It is purely combinational and reusable by a future ROM1/ROM2 split scheduler.

Test Plan:
All scenarios use ROMA_W=4 and LAST_ADDR=15.
1. Full run: start with first=0, last=3, tw_ready=1 -> 22 consecutive issues: stage0 k=0..15, stage1 k=0..3, stage2 k=0, stage3 k=0. At stage0 k=5, MA0/1/2=5/10/15. At k=6, MA1/MA2=12/2 (wrap). tw_last only on the 22nd set; done 2 cycles after the last issue; busy spans start+1 through the done cycle.
2. Backpressure: first=last=1; tw_ready=0 for 3 cycles after the first tw_valid -> ROM_CEN=1, MA0=1 held, tw_valid held with stage=1. On release, k=1..3 follow with no loss or duplicate; 4 sets total.
3. Reversed config: first=2, last=0 -> only stage 2, a single set with MA=0/0/0; tw_last=1; done pulses.
4. Abort in stage 0 at k=7 -> next cycle IDLE, ROM_CEN=1, tw_valid=0, no done. A following start with first=last=3 gives a single set (k=0) and done.
5. Start during busy and simultaneous start+abort in IDLE -> both ignored, state unchanged.
6. rst_n low for 1 cycle mid stage 1 -> all outputs at reset values asynchronously; after release, restart works identically to scenario 1.
